// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-master state type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } rd_state_t;

  // A beat breaks the length contract if RLAST disagrees with "this is beat len".
  function automatic logic beat_len_err(input logic rlast, input logic [7:0] cnt,
                                        input logic [7:0] len);
    return rlast ^ (cnt == len);
  endfunction

endpackage

// File: rtl/axi_rd_slice.sv
// Single-entry valid/ready output register; holds payload stable until accepted.
module axi_rd_slice #(
  parameter int unsigned W = 66
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 read master: one INCR burst in flight, per-burst sticky error on the last beat.
module axi_rd_master #(
  parameter int unsigned   AW     = 32,
  parameter int unsigned   DW     = 64,
  parameter int unsigned   IDW    = 4,
  parameter logic [IDW-1:0] ID_VAL = '0
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [AW-1:0]  req_addr,
  input  logic [7:0]     req_len,
  input  logic [2:0]     req_size,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [DW-1:0]  resp_data,
  output logic           resp_last,
  output logic           resp_err,
  output logic           ARVALID,
  input  logic           ARREADY,
  output logic [AW-1:0]  ARADDR,
  output logic [7:0]     ARLEN,
  output logic [2:0]     ARSIZE,
  output logic [1:0]     ARBURST,
  output logic [2:0]     ARPROT,
  output logic [IDW-1:0] ARID,
  input  logic           RVALID,
  output logic           RREADY,
  input  logic [DW-1:0]  RDATA,
  input  logic [1:0]     RRESP,
  input  logic           RLAST,
  input  logic [IDW-1:0] RID
);
  import axi_pkg::*;

  rd_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          req_fire, r_fire, slice_in_valid, slice_in_ready;
  logic          own_err, len_err, beat_err;
  logic [DW+1:0] beat_payload, resp_payload;

  // A pending last response keeps the next request out until it is consumed.
  assign req_ready = (state_q == StIdle) && !(resp_valid && resp_last);
  assign req_fire  = req_valid && req_ready;

  assign ARVALID = (state_q == StAddr);
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = BURST_INCR;
  assign ARPROT  = 3'b000;
  assign ARID    = ID_VAL;

  assign slice_in_valid = RVALID && (state_q == StData);
  assign RREADY         = (state_q == StData) && slice_in_ready;
  assign r_fire         = RVALID && RREADY;

  assign own_err  = (RRESP != RESP_OKAY) || (RID != ID_VAL);
  assign len_err  = beat_len_err(RLAST, cnt_q, len_q);
  // Non-last beats report only their own error; the last beat carries the whole burst's.
  assign beat_err = RLAST ? (err_q || own_err || len_err) : own_err;
  assign beat_payload = {RLAST, beat_err, RDATA};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          addr_d  = req_addr;
          len_d   = req_len;
          size_d  = req_size;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (ARREADY) begin
          state_d = StData;
        end
      end
      StData: begin
        if (r_fire) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q || own_err || len_err;
          if (RLAST) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  axi_rd_slice #(
    .W(DW + 2)
  ) u_slice (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .in_valid_i  (slice_in_valid),
    .in_ready_o  (slice_in_ready),
    .in_data_i   (beat_payload),
    .out_valid_o (resp_valid),
    .out_ready_i (resp_ready),
    .out_data_o  (resp_payload)
  );

  assign resp_last = resp_payload[DW+1];
  assign resp_err  = resp_payload[DW];
  assign resp_data = resp_payload[DW-1:0];

endmodule
